// File: rtl/uart_wb_bridge_if.sv
// Wishbone initiator/target bundle used by the UART command bridge.
interface uart_wb_bridge_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/uart_wb_bridge.sv
// Byte-stream command bridge: 'R'/'W' + 4 address bytes (+ 4 data bytes) become one
// Wishbone cycle; the result returns as read data, 0x06 (write ok) or 0x15 (timeout).
module uart_wb_bridge #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  uart_wb_bridge_if.master wb
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  BYTE_ACK     = 8'h06;
  localparam logic [7:0]  BYTE_NAK     = 8'h15;

  state_t      state_reg;
  logic [1:0]  byte_idx_reg;
  logic [15:0] timer_reg;
  logic        error_reg;
  logic [31:0] resp_reg;

  assign busy = (state_reg != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= S_IDLE;
      byte_idx_reg <= 2'd0;
      timer_reg    <= 16'd0;
      error_reg    <= 1'b0;
      resp_reg     <= 32'd0;
      tx_data      <= 8'd0;
      tx_valid     <= 1'b0;
      wb.cyc_o     <= 1'b0;
      wb.stb_o     <= 1'b0;
      wb.we_o      <= 1'b0;
      wb.adr_o     <= 32'd0;
      wb.sel_o     <= 4'd0;
      wb.dat_o     <= 32'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (rx_valid && (rx_data == 8'h52 || rx_data == 8'h57)) begin
            wb.we_o      <= (rx_data == 8'h57);
            byte_idx_reg <= 2'd0;
            state_reg    <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            wb.adr_o     <= {wb.adr_o[23:0], rx_data};
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              if (wb.we_o) begin
                state_reg <= S_DATA;
              end else begin
                state_reg <= S_BUS;
                wb.cyc_o  <= 1'b1;
                wb.stb_o  <= 1'b1;
                wb.sel_o  <= 4'hF;
                timer_reg <= 16'd0;
                error_reg <= 1'b0;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            wb.dat_o     <= {wb.dat_o[23:0], rx_data};
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              state_reg <= S_BUS;
              wb.cyc_o  <= 1'b1;
              wb.stb_o  <= 1'b1;
              wb.sel_o  <= 4'hF;
              timer_reg <= 16'd0;
              error_reg <= 1'b0;
            end
          end
        end

        S_BUS: begin
          // ack wins over a timeout landing on the same cycle
          if (wb.ack_i || timer_reg == TIMEOUT_LAST) begin
            state_reg    <= S_RESP;
            wb.cyc_o     <= 1'b0;
            wb.stb_o     <= 1'b0;
            wb.sel_o     <= 4'd0;
            tx_valid     <= 1'b1;
            byte_idx_reg <= 2'd0;
            if (!wb.ack_i) begin
              error_reg <= 1'b1;
              tx_data   <= BYTE_NAK;
            end else if (wb.we_o) begin
              tx_data <= BYTE_ACK;
            end else begin
              resp_reg <= wb.dat_i;
              tx_data  <= wb.dat_i[31:24];
            end
          end else begin
            timer_reg <= timer_reg + 16'd1;
          end
        end

        S_RESP: begin
          if (tx_valid && tx_ready) begin
            if (wb.we_o || error_reg || byte_idx_reg == 2'd3) begin
              state_reg    <= S_IDLE;
              tx_valid     <= 1'b0;
              tx_data      <= 8'd0;
              byte_idx_reg <= 2'd0;
            end else begin
              // resp_reg shifts so its second byte is always the next one to send
              byte_idx_reg <= byte_idx_reg + 2'd1;
              tx_data      <= resp_reg[23:16];
              resp_reg     <= {resp_reg[23:0], 8'h00};
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
